// File: rtl/reg_rename_file_pkg.sv
// Shared widths, the "no producer" label value, and bus structs for the rename file.
package reg_rename_file_pkg;

  localparam int LABEL_W  = 4;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 6;

  localparam logic [LABEL_W-1:0] LABEL_NONE = '0;

  // Common data bus broadcast
  typedef struct packed {
    logic               valid;
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0]  data;
  } cdb_t;

  // Rename request from issue
  typedef struct packed {
    logic               en;
    logic [ADDR_W-1:0]  addr;
    logic [LABEL_W-1:0] label;
  } issue_req_t;

  // Number of set bits, used for the pending-register count
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt = cnt + CNT_W'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/reg_rename_file_entry.sv
// One architectural register: data, producer label, CDB capture and rename set.
import reg_rename_file_pkg::*;

module reg_status_entry (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               issue_hit,
  input  logic [LABEL_W-1:0] issue_label,
  input  cdb_t               cdb,
  output logic [DATA_W-1:0]  data,
  output logic [LABEL_W-1:0] label,
  output logic [LABEL_W-1:0] label_nxt
);

  logic              cdb_hit;
  logic [DATA_W-1:0] data_nxt;

  // Broadcast match and next-state: a new rename beats the clearing broadcast,
  // flush beats the rename, but the broadcast data is always captured.
  always_comb begin
    cdb_hit   = cdb.valid && (cdb.label != LABEL_NONE) && (label == cdb.label);
    data_nxt  = cdb_hit ? cdb.data : data;
    label_nxt = label;
    if (flush)          label_nxt = LABEL_NONE;
    else if (issue_hit) label_nxt = issue_label;
    else if (cdb_hit)   label_nxt = LABEL_NONE;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      label <= LABEL_NONE;
    end else begin
      data  <= data_nxt;
      label <= label_nxt;
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Register rename/status file: 32 x (data, producer label), two combinational
// read ports, rename on issue, capture on CDB broadcast, flush of pending renames.
// Optional macro REGFILE_CDB_BYPASS_EN forwards a matching broadcast to the read
// ports in the same cycle.
import reg_rename_file_pkg::*;

module reg_rename_file (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  readAddr1,
  input  logic [ADDR_W-1:0]  readAddr2,
  output logic [LABEL_W-1:0] labelOut1,
  output logic [LABEL_W-1:0] labelOut2,
  output logic [DATA_W-1:0]  dataOut1,
  output logic [DATA_W-1:0]  dataOut2,
  input  logic               issueEn,
  input  logic [ADDR_W-1:0]  issueAddr,
  input  logic [LABEL_W-1:0] issueLabel,
  input  logic               cdbValid,
  input  logic [LABEL_W-1:0] cdbLabel,
  input  logic [DATA_W-1:0]  cdbData,
  input  logic               flush,
  output logic [CNT_W-1:0]   pendingCount
);

  cdb_t       cdb;
  issue_req_t iss;

  logic [NUM_REGS-1:0][DATA_W-1:0]  ent_data;
  logic [NUM_REGS-1:0][LABEL_W-1:0] ent_label;
  logic [NUM_REGS-1:0][LABEL_W-1:0] ent_label_nxt;
  logic [NUM_REGS-1:0]              busy_nxt;

  assign cdb = '{valid: cdbValid, label: cdbLabel, data: cdbData};
  assign iss = '{en: issueEn, addr: issueAddr, label: issueLabel};

  // r0 is hardwired: always ready, always zero
  assign ent_data[0]      = '0;
  assign ent_label[0]     = LABEL_NONE;
  assign ent_label_nxt[0] = LABEL_NONE;

  genvar g;
  generate
    for (g = 1; g < NUM_REGS; g++) begin : g_ent
      reg_status_entry u_ent (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .issue_hit   (iss.en && (iss.addr == ADDR_W'(g)) && (iss.label != LABEL_NONE)),
        .issue_label (iss.label),
        .cdb         (cdb),
        .data        (ent_data[g]),
        .label       (ent_label[g]),
        .label_nxt   (ent_label_nxt[g])
      );
    end
  endgenerate

  // Busy mask of the state the next edge will load
  always_comb begin
    busy_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) busy_nxt[i] = (ent_label_nxt[i] != LABEL_NONE);
  end

  // Registered pending count, tracking the entries' next state
  always_ff @(posedge clk) begin
    if (rst) pendingCount <= '0;
    else     pendingCount <= popcount(busy_nxt);
  end

  // Combinational read ports, optionally forwarding a matching broadcast
  always_comb begin
    labelOut1 = ent_label[readAddr1];
    dataOut1  = ent_data[readAddr1];
    labelOut2 = ent_label[readAddr2];
    dataOut2  = ent_data[readAddr2];
`ifdef REGFILE_CDB_BYPASS_EN
    if (cdb.valid && (cdb.label != LABEL_NONE) && (labelOut1 == cdb.label)) begin
      labelOut1 = LABEL_NONE;
      dataOut1  = cdb.data;
    end
    if (cdb.valid && (cdb.label != LABEL_NONE) && (labelOut2 == cdb.label)) begin
      labelOut2 = LABEL_NONE;
      dataOut2  = cdb.data;
    end
`endif
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file; expected values are hand-derived constants.
module tb_reg_rename_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  readAddr1, readAddr2;
  logic [3:0]  labelOut1, labelOut2;
  logic [31:0] dataOut1, dataOut2;
  logic        issueEn;
  logic [4:0]  issueAddr;
  logic [3:0]  issueLabel;
  logic        cdbValid;
  logic [3:0]  cdbLabel;
  logic [31:0] cdbData;
  logic        flush;
  logic [5:0]  pendingCount;

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  reg_rename_file dut (
    .clk(clk), .rst(rst),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .labelOut1(labelOut1), .labelOut2(labelOut2),
    .dataOut1(dataOut1), .dataOut2(dataOut2),
    .issueEn(issueEn), .issueAddr(issueAddr), .issueLabel(issueLabel),
    .cdbValid(cdbValid), .cdbLabel(cdbLabel), .cdbData(cdbData),
    .flush(flush), .pendingCount(pendingCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] a, input logic [3:0] l);
    issueEn = 1'b1; issueAddr = a; issueLabel = l;
  endtask

  task automatic bcast(input logic [3:0] l, input logic [31:0] d);
    cdbValid = 1'b1; cdbLabel = l; cdbData = d;
  endtask

  task automatic idle();
    issueEn = 1'b0; cdbValid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; readAddr1 = '0; readAddr2 = '0;
    issueEn = 0; issueAddr = '0; issueLabel = '0;
    cdbValid = 0; cdbLabel = '0; cdbData = '0; flush = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    readAddr1 = 5; #1;
    chk("rst_r5_label", 32'(labelOut1), 0);
    chk("rst_r5_data", dataOut1, 0);
    chk("rst_pending", 32'(pendingCount), 0);

    // rename then capture
    issue(3, 2); tick(); idle();
    readAddr1 = 3; #1;
    chk("r3_label_2", 32'(labelOut1), 2);
    chk("r3_pending_1", 32'(pendingCount), 1);
    bcast(2, 32'hDEADBEEF); tick(); idle(); #1;
    chk("r3_label_clr", 32'(labelOut1), 0);
    chk("r3_data", dataOut1, 32'hDEADBEEF);
    chk("r3_pending_0", 32'(pendingCount), 0);

    // one broadcast clears two registers
    issue(4, 5); tick(); issue(7, 5); tick(); idle();
    chk("two_pending", 32'(pendingCount), 2);
    bcast(5, 32'h12); tick(); idle();
    readAddr1 = 4; readAddr2 = 7; #1;
    chk("r4_data", dataOut1, 32'h12);
    chk("r4_label", 32'(labelOut1), 0);
    chk("r7_data", dataOut2, 32'h12);
    chk("r7_label", 32'(labelOut2), 0);

    // rename and broadcast to the same entry: data captured, new label kept
    issue(6, 1); tick();
    issue(6, 3); bcast(1, 32'h55); tick(); idle();
    readAddr1 = 6; #1;
    chk("r6_data", dataOut1, 32'h55);
    chk("r6_label", 32'(labelOut1), 3);
    chk("r6_pending", 32'(pendingCount), 1);

    // label-0 broadcast must not touch ready registers
    bcast(0, 32'hBAD); tick(); idle();
    readAddr1 = 5; #1;
    chk("cdb0_r5_data", dataOut1, 0);

    // issue reuses the broadcasting tag
    issue(10, 7); tick(); issue(11, 7); tick();
    issue(10, 7); bcast(7, 32'hAB); tick(); idle();
    readAddr1 = 10; readAddr2 = 11; #1;
    chk("r10_label", 32'(labelOut1), 7);
    chk("r10_data", dataOut1, 32'hAB);
    chk("r11_label", 32'(labelOut2), 0);
    chk("r11_data", dataOut2, 32'hAB);

    // same-cycle read of a broadcasting producer
    issue(8, 4); tick(); idle();
    bcast(4, 32'h99); readAddr1 = 8; #1;
`ifdef REGFILE_CDB_BYPASS_EN
    chk("byp_label", 32'(labelOut1), 0);
    chk("byp_data", dataOut1, 32'h99);
`else
    chk("nobyp_label", 32'(labelOut1), 4);
    chk("nobyp_data", dataOut1, 0);
`endif
    tick(); idle(); #1;
    chk("r8_label_after", 32'(labelOut1), 0);
    chk("r8_data_after", dataOut1, 32'h99);

    // flush: pending r6(3), r10(7) plus three new renames
    issue(12, 8); tick(); issue(13, 9); tick(); issue(14, 10); tick(); idle();
    chk("pre_flush_pending", 32'(pendingCount), 5);
    flush = 1'b1; issue(9, 6); bcast(8, 32'h77); tick(); idle();
    readAddr1 = 9; readAddr2 = 12; #1;
    chk("flush_pending", 32'(pendingCount), 0);
    chk("flush_r9_label", 32'(labelOut1), 0);
    chk("flush_r12_label", 32'(labelOut2), 0);
    chk("flush_r12_data", dataOut2, 32'h77);
    readAddr1 = 6; #1;
    chk("flush_r6_data_kept", dataOut1, 32'h55);

    // issue to r0 and issue with label 0 are ignored
    issue(0, 5); tick(); issue(5, 0); tick(); idle();
    readAddr1 = 0; readAddr2 = 5; #1;
    chk("r0_label", 32'(labelOut1), 0);
    chk("r0_data", dataOut1, 0);
    chk("r5_label0_issue", 32'(labelOut2), 0);
    chk("ignored_pending", 32'(pendingCount), 0);

    // reset overrides everything
    issue(2, 1); tick();
    rst = 1'b1; issue(3, 2); bcast(1, 32'hFF); tick(); rst = 1'b0; idle();
    readAddr1 = 2; readAddr2 = 3; #1;
    chk("rst2_r2_label", 32'(labelOut1), 0);
    chk("rst2_r2_data", dataOut1, 0);
    chk("rst2_r3_label", 32'(labelOut2), 0);
    chk("rst2_r3_data", dataOut2, 0);
    chk("rst2_pending", 32'(pendingCount), 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/reg_rename_file.md
REG_RENAME_FILE -- requirements
Module: reg_rename_file

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` and `rst`.
REQ-002 `clk` SHALL be an input, 1 bit: the system clock; all state updates on its rising edge.
REQ-003 `rst` SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 `readAddr1` and `readAddr2` SHALL each be inputs, 5 bits: read register indices from issue (rs, rt).
REQ-005 `labelOut1` and `labelOut2` SHALL each be outputs, 4 bits: pending producer tag per read port; 0 means the value is ready.
REQ-006 `dataOut1` and `dataOut2` SHALL each be outputs, 32 bits: register value per read port; valid only when the matching label is 0.
REQ-007 `issueEn` SHALL be an input, 1 bit: rename request.
REQ-008 `issueAddr` SHALL be an input, 5 bits: destination register to rename.
REQ-009 `issueLabel` SHALL be an input, 4 bits: reservation-station tag that will produce the destination value.
REQ-010 `cdbValid`, `cdbLabel` and `cdbData` SHALL be inputs of 1, 4 and 32 bits respectively: the common data bus broadcast.
REQ-011 `flush` SHALL be an input, 1 bit: discard all pending renames.
REQ-012 `pendingCount` SHALL be an output, 6 bits: number of registers with a nonzero label.

Function
REQ-013 State SHALL be 32 entries, each holding 32-bit data and a 4-bit label; label 0 means no pending producer.
REQ-014 Read ports SHALL be combinational: zero-cycle latency from `readAddr` to label/data.
REQ-015 On `issueEn` with `issueAddr` != 0 and `issueLabel` != 0, the entry label SHALL become `issueLabel` at the next edge; data SHALL be unchanged.
REQ-016 Issue to register 0, or with `issueLabel` 0, SHALL be ignored.
REQ-017 On `cdbValid`, every entry whose label equals `cdbLabel` (nonzero) SHALL take `cdbData` and clear its label at the next edge; multiple entries may match.
REQ-018 A `cdbValid` broadcast with `cdbLabel` 0 SHALL be ignored.
REQ-019 When issue and a matching broadcast hit the same entry in one cycle, data SHALL take `cdbData` and the label SHALL take `issueLabel` (the new rename wins).
REQ-020 When issue reuses a tag that is currently broadcasting, the issued entry SHALL keep the new label; only the other matching entries clear.
REQ-021 On `flush`, all labels SHALL clear at the next edge and data SHALL be retained; a broadcast in the same cycle still writes data; `flush` SHALL override issue.
REQ-022 Register 0 SHALL read data 0 and label 0 always.
REQ-023 `pendingCount` SHALL be registered: the popcount of nonzero labels after each edge, range 0..31.

Reset
REQ-024 While `rst` is high at a clock edge, all data and labels SHALL become 0 and `pendingCount` SHALL become 0.
REQ-025 `rst` SHALL override issue, broadcast and `flush`; read outputs SHALL then reflect zeroed state combinationally.

Configuration
REQ-026 With `REGFILE_CDB_BYPASS_EN` defined, a read whose stored label equals `cdbLabel` while `cdbValid` is high SHALL return `cdbData` with label 0 in the same cycle.
REQ-027 Without `REGFILE_CDB_BYPASS_EN`, reads SHALL return stored state only; the cleared value appears one cycle after the broadcast.

Structure
REQ-028 The shared header SHALL define label width (4), register count (32), data width (32), and the no-producer label value (0).
REQ-029 The per-register cell (data, label, CDB match/clear, issue set) SHALL be one sub-module, `reg_status_entry`, instantiated 31 times (register 0 hardwired).

Verification
REQ-030 Reset, then read r5 -> label 0, data 0; `pendingCount` 0.
REQ-031 Issue r3 tag 2; next cycle read r3 -> label 2; broadcast tag 2, data 0xDEADBEEF -> next cycle r3 label 0, data 0xDEADBEEF; `pendingCount` 1 then 0.
REQ-032 Rename r4 and r7 both to tag 5; broadcast tag 5, data 0x12 -> both registers hold 0x12 with label 0.
REQ-033 Same cycle: issue r6 tag 3 and broadcast tag 1 for r6, data 0x55 -> r6 data 0x55, label 3.
REQ-034 With bypass enabled, r8 pending on tag 4 and broadcast tag 4, data 0x99 -> same-cycle read of r8 gives label 0, data 0x99; without bypass -> label 4 that cycle.
REQ-035 Rename 3 registers, then assert `flush` with issue r9 tag 6 -> all labels 0, r9 not renamed, `pendingCount` 0; issue to r0 -> r0 stays label 0.
